// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready operand intake and a registered valid/ready result port.
// Shifts run one bit per cycle unless ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | empty, in_ready=1
// SHIFT | iterative shift in flight, in_ready=0 (absent with ALU_EXEC_FAST_SHIFT_EN)
// DONE  | result held, out_valid=1, in_ready=out_ready
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_AND  = 4'd2;
    localparam logic [3:0] SEL_OR   = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_SLT  = 4'd5;
    localparam logic [3:0] SEL_SLTU = 4'd6;
    localparam logic [3:0] SEL_SLL  = 4'd7;
    localparam logic [3:0] SEL_SRL  = 4'd8;
    localparam logic [3:0] SEL_SRA  = 4'd9;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t            state_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic [TAG_W-1:0]  tag_out_q;

    logic [4:0]        shamt;
    logic [XLEN-1:0]   alu_d;
    logic              accept;
    logic              handoff;

    assign shamt   = op_b[4:0];
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept  = in_valid && in_ready;
    assign handoff = out_valid_q && out_ready;

    always_comb begin
        alu_d = op_a + op_b;
        case (alu_sel)
            SEL_SUB:  alu_d = op_a - op_b;
            SEL_AND:  alu_d = op_a & op_b;
            SEL_OR:   alu_d = op_a | op_b;
            SEL_XOR:  alu_d = op_a ^ op_b;
            SEL_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            SEL_SLTU: alu_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            SEL_SLL:  alu_d = op_a << shamt;
            SEL_SRL:  alu_d = op_a >> shamt;
            SEL_SRA:  alu_d = $unsigned($signed(op_a) >>> shamt);
`else
            // only reached with shamt==0; nonzero amounts go through SHIFT
            SEL_SLL, SEL_SRL, SEL_SRA: alu_d = op_a;
`endif
            default:  alu_d = op_a + op_b;
        endcase
    end

`ifndef ALU_EXEC_FAST_SHIFT_EN
    logic [XLEN-1:0]   sh_q;
    logic [XLEN-1:0]   sh_d;
    logic [4:0]        cnt_q;
    logic              sh_left_q;
    logic              sh_arith_q;
    logic [TAG_W-1:0]  sh_tag_q;
    logic              is_shift;

    assign is_shift = (alu_sel == SEL_SLL) || (alu_sel == SEL_SRL) || (alu_sel == SEL_SRA);

    always_comb begin
        if (sh_left_q) begin
            sh_d = {sh_q[XLEN-2:0], 1'b0};
        end else begin
            sh_d = {sh_arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            tag_out_q   <= '0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            sh_q        <= '0;
            cnt_q       <= '0;
            sh_left_q   <= 1'b0;
            sh_arith_q  <= 1'b0;
            sh_tag_q    <= '0;
`endif
        end else begin
            case (state_q)
`ifndef ALU_EXEC_FAST_SHIFT_EN
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_q    <= sh_d;
                        zero_q      <= (sh_d == '0);
                        tag_out_q   <= sh_tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                default: begin
                    if (accept) begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
                        if (is_shift && (shamt != 5'd0)) begin
                            sh_q        <= op_a;
                            cnt_q       <= shamt;
                            sh_left_q   <= (alu_sel == SEL_SLL);
                            sh_arith_q  <= (alu_sel == SEL_SRA);
                            sh_tag_q    <= tag_in;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= SHIFT;
                        end else
`endif
                        begin
                            result_q    <= alu_d;
                            zero_q      <= (alu_d == '0);
                            tag_out_q   <= tag_in;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else if (handoff) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign tag_out   = tag_out_q;

endmodule
